// File: rtl/up_multicycle_ctrl_pkg.sv
// Shared types and constants for the UP multicycle controller:
// FSM states, RV64 opcodes, ALU operation codes and ALU B-mux selects.
package up_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        LUI,
        R_WB,
        MEM_ADDR,
        MEM_READ,
        LOAD_WB,
        STORE,
        BRANCH,
        HALT
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_SUB = 7'b0100000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    localparam logic [1:0] MUXB_REGB   = 2'b00;
    localparam logic [1:0] MUXB_FOUR   = 2'b01;
    localparam logic [1:0] MUXB_IMM    = 2'b10;
    localparam logic [1:0] MUXB_IMMSH1 = 2'b11;

    // beq takes on equal operands (sub result zero), bne on unequal ones.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        return ((f3 == F3_BEQ) && zero) || ((f3 == F3_BNE) && !zero);
    endfunction

endpackage

// File: rtl/up_wait_counter.sv
// Memory wait counter: counts 0..MEM_WAIT and then holds; done marks the
// cycle in which memory data is valid. A clear restarts it at zero.
module up_wait_counter
    import up_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic done
);

    localparam logic [2:0] LAST = 3'(MEM_WAIT);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/up_multicycle_ctrl.sv
// Multicycle control FSM for the UP datapath (add/sub/addi/ld/sd/beq/bne/lui,
// ebreak and illegal opcodes halt). Moore outputs except branch pc_write.
module up_multicycle_ctrl
    import up_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       alu_zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       instr_mem_wr,
    output logic       data_mem_wr,
    output logic       sel_mux_a,
    output logic [1:0] sel_mux_b,
    output logic       sel_mux_mem,
    output logic       sel_mux_pc,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       load_a,
    output logic       load_b,
    output logic       load_mdr,
    output logic       load_aluout,
    output logic       exit_state
);

    state_t state_q;
    state_t state_d;
    logic   wait_done;
    logic   wait_clear;

    assign wait_clear   = (state_d != state_q);
    assign instr_mem_wr = 1'b0;

    up_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk  (clk),
        .rst  (rst),
        .clear(wait_clear),
        .done (wait_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // LUI is computed as regA + imm: the datapath reads x0 into regA for U-type
    // instructions and the immediate generator supplies imm[31:12] << 12.
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        data_mem_wr = 1'b0;
        sel_mux_a   = 1'b0;
        sel_mux_b   = MUXB_REGB;
        sel_mux_mem = 1'b0;
        sel_mux_pc  = 1'b0;
        alu_op      = ALU_PASS;
        reg_write   = 1'b0;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_mdr    = 1'b0;
        load_aluout = 1'b0;
        exit_state  = 1'b0;
        case (state_q)
            FETCH: begin
                sel_mux_b = MUXB_FOUR;
                alu_op    = ALU_ADD;
                if (wait_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                load_a      = 1'b1;
                load_b      = 1'b1;
                sel_mux_b   = MUXB_IMMSH1;
                alu_op      = ALU_ADD;
                load_aluout = 1'b1;
                case (opcode)
                    OP_RTYPE:          state_d = EXEC_R;
                    OP_ITYPE:          state_d = EXEC_I;
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_LUI:            state_d = LUI;
                    default:           state_d = HALT;
                endcase
            end
            EXEC_R: begin
                sel_mux_a   = 1'b1;
                alu_op      = (funct7 == FUNCT7_SUB) ? ALU_SUB : ALU_ADD;
                load_aluout = 1'b1;
                state_d     = R_WB;
            end
            EXEC_I, LUI: begin
                sel_mux_a   = 1'b1;
                sel_mux_b   = MUXB_IMM;
                alu_op      = ALU_ADD;
                load_aluout = 1'b1;
                state_d     = R_WB;
            end
            R_WB: begin
                sel_mux_a = 1'b1;
                alu_op    = ALU_ADD;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            MEM_ADDR: begin
                sel_mux_a   = 1'b1;
                sel_mux_b   = MUXB_IMM;
                alu_op      = ALU_ADD;
                load_aluout = 1'b1;
                state_d     = (opcode == OP_LOAD) ? MEM_READ : STORE;
            end
            MEM_READ: begin
                if (wait_done) begin
                    load_mdr = 1'b1;
                    state_d  = LOAD_WB;
                end
            end
            LOAD_WB: begin
                reg_write   = 1'b1;
                sel_mux_mem = 1'b1;
                state_d     = FETCH;
            end
            STORE: begin
                data_mem_wr = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                sel_mux_a  = 1'b1;
                alu_op     = ALU_SUB;
                sel_mux_pc = 1'b1;
                pc_write   = branch_taken(funct3, alu_zero);
                state_d    = FETCH;
            end
            HALT: begin
                exit_state = 1'b1;
            end
            default: state_d = HALT;
        endcase
        // Outputs drop to zero as soon as reset is asserted, before any clock edge.
        if (!rst) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            data_mem_wr = 1'b0;
            sel_mux_a   = 1'b0;
            sel_mux_b   = MUXB_REGB;
            sel_mux_mem = 1'b0;
            sel_mux_pc  = 1'b0;
            alu_op      = ALU_PASS;
            reg_write   = 1'b0;
            load_a      = 1'b0;
            load_b      = 1'b0;
            load_mdr    = 1'b0;
            load_aluout = 1'b0;
            exit_state  = 1'b0;
        end
    end

endmodule

// File: tb/tb_up_multicycle_ctrl.sv
// Directed self-checking bench for up_multicycle_ctrl with MEM_WAIT=1.
// Every output is compared each cycle against a hand-built expected vector.
module tb_up_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       alu_zero = 1'b0;
    logic       pc_write, ir_write, instr_mem_wr, data_mem_wr, sel_mux_a;
    logic [1:0] sel_mux_b;
    logic       sel_mux_mem, sel_mux_pc;
    logic [2:0] alu_op;
    logic       reg_write, load_a, load_b, load_mdr, load_aluout, exit_state;

    int testsRun = 0;
    int testsFailed = 0;

    up_multicycle_ctrl #(.MEM_WAIT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_zero    (alu_zero),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .instr_mem_wr(instr_mem_wr),
        .data_mem_wr (data_mem_wr),
        .sel_mux_a   (sel_mux_a),
        .sel_mux_b   (sel_mux_b),
        .sel_mux_mem (sel_mux_mem),
        .sel_mux_pc  (sel_mux_pc),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .load_a      (load_a),
        .load_b      (load_b),
        .load_mdr    (load_mdr),
        .load_aluout (load_aluout),
        .exit_state  (exit_state)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {pc_write, ir_write, instr_mem_wr, data_mem_wr, sel_mux_a, sel_mux_b,
                  sel_mux_mem, sel_mux_pc, alu_op, reg_write, load_a, load_b,
                  load_mdr, load_aluout, exit_state};

    function automatic logic [17:0] ov(input logic pcw, input logic irw, input logic dmw,
                                       input logic ma, input logic [1:0] mb, input logic mm,
                                       input logic mp, input logic [2:0] op, input logic rw,
                                       input logic la, input logic lb, input logic lmdr,
                                       input logic lao, input logic ex);
        return {pcw, irw, 1'b0, dmw, ma, mb, mm, mp, op, rw, la, lb, lmdr, lao, ex};
    endfunction

    // Expected output vector of every state, written out by hand.
    logic [17:0] ZERO, F0, F1, DEC, EXR_ADD, EXR_SUB, EXI, RWB, MA, MR0, MR1, LWB, ST, BR_T, BR_N, HLT;

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z);
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        alu_zero = z;
    endtask

    task automatic checkOutput(input string tag, input logic [17:0] expected);
        testsRun++;
        assert (obs === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %b required %b", tag, obs, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        ZERO    = ov(0,0,0, 0,2'b00,0,0,3'b000, 0,0,0,0,0,0);
        F0      = ov(0,0,0, 0,2'b01,0,0,3'b001, 0,0,0,0,0,0);
        F1      = ov(1,1,0, 0,2'b01,0,0,3'b001, 0,0,0,0,0,0);
        DEC     = ov(0,0,0, 0,2'b11,0,0,3'b001, 0,1,1,0,1,0);
        EXR_ADD = ov(0,0,0, 1,2'b00,0,0,3'b001, 0,0,0,0,1,0);
        EXR_SUB = ov(0,0,0, 1,2'b00,0,0,3'b010, 0,0,0,0,1,0);
        EXI     = ov(0,0,0, 1,2'b10,0,0,3'b001, 0,0,0,0,1,0);
        RWB     = ov(0,0,0, 1,2'b00,0,0,3'b001, 1,0,0,0,0,0);
        MA      = ov(0,0,0, 1,2'b10,0,0,3'b001, 0,0,0,0,1,0);
        MR0     = ov(0,0,0, 0,2'b00,0,0,3'b000, 0,0,0,0,0,0);
        MR1     = ov(0,0,0, 0,2'b00,0,0,3'b000, 0,0,0,1,0,0);
        LWB     = ov(0,0,0, 0,2'b00,1,0,3'b000, 1,0,0,0,0,0);
        ST      = ov(0,0,1, 0,2'b00,0,0,3'b000, 0,0,0,0,0,0);
        BR_T    = ov(1,0,0, 1,2'b00,0,1,3'b010, 0,0,0,0,0,0);
        BR_N    = ov(0,0,0, 1,2'b00,0,1,3'b010, 0,0,0,0,0,0);
        HLT     = ov(0,0,0, 0,2'b00,0,0,3'b000, 0,0,0,0,0,1);

        applyStimulus(7'b0110011, 3'b000, 7'b0000000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", ZERO);
        rst = 1'b1;
        #1 checkOutput("add_fetch0", F0);

        // add x3,x1,x2: F,F,D,EXEC_R,R_WB
        nextCycle(); checkOutput("add_fetch1", F1);
        nextCycle(); checkOutput("add_decode", DEC);
        nextCycle(); checkOutput("add_exec", EXR_ADD);
        nextCycle(); checkOutput("add_wb", RWB);
        nextCycle(); checkOutput("sub_fetch0", F0);

        applyStimulus(7'b0110011, 3'b000, 7'b0100000, 1'b0);
        nextCycle(); checkOutput("sub_fetch1", F1);
        nextCycle(); checkOutput("sub_decode", DEC);
        nextCycle(); checkOutput("sub_exec", EXR_SUB);
        nextCycle(); checkOutput("sub_wb", RWB);
        nextCycle(); checkOutput("addi_fetch0", F0);

        applyStimulus(7'b0010011, 3'b000, 7'b0000000, 1'b0);
        nextCycle(); checkOutput("addi_fetch1", F1);
        nextCycle(); checkOutput("addi_decode", DEC);
        nextCycle(); checkOutput("addi_exec", EXI);
        nextCycle(); checkOutput("addi_wb", RWB);
        nextCycle(); checkOutput("lui_fetch0", F0);

        applyStimulus(7'b0110111, 3'b000, 7'b0000000, 1'b0);
        nextCycle(); checkOutput("lui_fetch1", F1);
        nextCycle(); checkOutput("lui_decode", DEC);
        nextCycle(); checkOutput("lui_exec", EXI);
        nextCycle(); checkOutput("lui_wb", RWB);
        nextCycle(); checkOutput("ld_fetch0", F0);

        // ld x5,8(x1): 7 cycles, load_mdr on the second MEM_READ cycle
        applyStimulus(7'b0000011, 3'b011, 7'b0000000, 1'b0);
        nextCycle(); checkOutput("ld_fetch1", F1);
        nextCycle(); checkOutput("ld_decode", DEC);
        nextCycle(); checkOutput("ld_addr", MA);
        nextCycle(); checkOutput("ld_read0", MR0);
        nextCycle(); checkOutput("ld_read1", MR1);
        nextCycle(); checkOutput("ld_wb", LWB);
        nextCycle(); checkOutput("sd_fetch0", F0);

        applyStimulus(7'b0100011, 3'b011, 7'b0000000, 1'b0);
        nextCycle(); checkOutput("sd_fetch1", F1);
        nextCycle(); checkOutput("sd_decode", DEC);
        nextCycle(); checkOutput("sd_addr", MA);
        nextCycle(); checkOutput("sd_store", ST);
        nextCycle(); checkOutput("beq_t_fetch0", F0);

        applyStimulus(7'b1100011, 3'b000, 7'b0000000, 1'b1);
        nextCycle(); checkOutput("beq_t_fetch1", F1);
        nextCycle(); checkOutput("beq_t_decode", DEC);
        nextCycle(); checkOutput("beq_taken", BR_T);
        nextCycle(); checkOutput("beq_n_fetch0", F0);

        applyStimulus(7'b1100011, 3'b000, 7'b0000000, 1'b0);
        nextCycle(); checkOutput("beq_n_fetch1", F1);
        nextCycle(); checkOutput("beq_n_decode", DEC);
        nextCycle(); checkOutput("beq_not_taken", BR_N);
        nextCycle(); checkOutput("bne_t_fetch0", F0);

        applyStimulus(7'b1100011, 3'b001, 7'b0000000, 1'b0);
        nextCycle(); checkOutput("bne_t_fetch1", F1);
        nextCycle(); checkOutput("bne_t_decode", DEC);
        nextCycle(); checkOutput("bne_taken", BR_T);
        nextCycle(); checkOutput("bne_n_fetch0", F0);

        applyStimulus(7'b1100011, 3'b001, 7'b0000000, 1'b1);
        nextCycle(); checkOutput("bne_n_fetch1", F1);
        nextCycle(); checkOutput("bne_n_decode", DEC);
        nextCycle(); checkOutput("bne_not_taken", BR_N);
        nextCycle(); checkOutput("rst_ld_fetch0", F0);

        // Asynchronous reset in the middle of a MEM_READ
        applyStimulus(7'b0000011, 3'b011, 7'b0000000, 1'b0);
        nextCycle(); checkOutput("rst_ld_fetch1", F1);
        nextCycle(); checkOutput("rst_ld_decode", DEC);
        nextCycle(); checkOutput("rst_ld_addr", MA);
        nextCycle(); checkOutput("rst_ld_read0", MR0);
        #2 rst = 1'b0;
        #1 checkOutput("async_rst_immediate", ZERO);
        nextCycle(); checkOutput("async_rst_held", ZERO);
        rst = 1'b1;
        #1 checkOutput("after_rst_fetch0", F0);

        // Illegal opcode parks in HALT
        applyStimulus(7'b1111111, 3'b000, 7'b0000000, 1'b0);
        nextCycle(); checkOutput("illegal_fetch1", F1);
        nextCycle(); checkOutput("illegal_decode", DEC);
        for (int i = 0; i < 20; i++) begin
            nextCycle(); checkOutput($sformatf("halt_sticky_%0d", i), HLT);
        end
        #2 rst = 1'b0;
        #1 checkOutput("halt_rst", ZERO);
        nextCycle();
        rst = 1'b1;
        #1 checkOutput("halt_exit_fetch0", F0);

        // ebreak also halts
        applyStimulus(7'b1110011, 3'b000, 7'b0000000, 1'b0);
        nextCycle(); checkOutput("ebreak_fetch1", F1);
        nextCycle(); checkOutput("ebreak_decode", DEC);
        nextCycle(); checkOutput("ebreak_halt", HLT);
        nextCycle(); checkOutput("ebreak_halt_held", HLT);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
